// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types for the FPU issue/result controller
package fpu_pkg;

    typedef logic [1:0]  fpu_op_t;
    typedef logic [31:0] fpu_word_t;

    typedef struct packed {
        fpu_word_t operand1;
        fpu_word_t operand2;
        fpu_op_t   operation;
    } fpu_req_t;

    typedef struct packed {
        fpu_word_t result;
        fpu_op_t   operation;
    } fpu_rsp_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module fpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - credit-based operand issue and result collection for a fixed-latency FPU
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int LATENCY   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InOperand1,
    input  logic [31:0] InOperand2,
    input  logic [1:0]  InOperation,
    output logic [31:0] FpuOperand1,
    output logic [31:0] FpuOperand2,
    output logic [1:0]  FpuOperation,
    input  logic [31:0] FpuResult,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutResult,
    output logic [1:0]  OutOperation,
    output logic        Busy
);

    localparam int CW = $clog2(OUT_DEPTH + 1);

    fpu_req_t           in_wdata;
    fpu_req_t           in_rdata;
    logic               in_full;
    logic               in_empty;
    fpu_rsp_t           res_wdata;
    fpu_rsp_t           out_rdata;
    logic               out_full;
    logic               out_empty;
    logic               res_push;
    logic               out_pop;
    logic               issue;
    logic [CW-1:0]      credits_used;
    logic [LATENCY-1:0] pipe_valid;
    fpu_op_t            pipe_tag [LATENCY];

    assign in_wdata = {InOperand1, InOperand2, InOperation};

    fpu_sync_fifo #(
        .WIDTH ($bits(fpu_req_t)),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (InValid),
        .wdata (in_wdata),
        .pop   (issue),
        .rdata (in_rdata),
        .full  (in_full),
        .empty (in_empty)
    );

    // A pop in the same cycle frees a credit, so issue may proceed at a full count.
    assign out_pop = !out_empty && OutReady;
    assign issue   = !in_empty && ((credits_used < CW'(OUT_DEPTH)) || out_pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FpuOperand1  <= '0;
            FpuOperand2  <= '0;
            FpuOperation <= '0;
        end else if (issue) begin
            FpuOperand1  <= in_rdata.operand1;
            FpuOperand2  <= in_rdata.operand2;
            FpuOperation <= in_rdata.operation;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_tag[0]   <= in_rdata.operation;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credits_used <= '0;
        end else begin
            case ({issue, out_pop})
                2'b10:   credits_used <= credits_used + 1'b1;
                2'b01:   credits_used <= credits_used - 1'b1;
                default: credits_used <= credits_used;
            endcase
        end
    end

    assign res_push  = pipe_valid[LATENCY-1];
    assign res_wdata = {FpuResult, pipe_tag[LATENCY-1]};

    fpu_sync_fifo #(
        .WIDTH ($bits(fpu_rsp_t)),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (res_push),
        .wdata (res_wdata),
        .pop   (out_pop),
        .rdata (out_rdata),
        .full  (out_full),
        .empty (out_empty)
    );

    // Credits reserve result space at issue time, so a write never meets a full FIFO.
    assert property (@(posedge CLK) disable iff (RST) !(res_push && out_full));

    assign InReady      = !in_full;
    assign OutValid     = !out_empty;
    assign OutResult    = out_rdata.result;
    assign OutOperation = out_rdata.operation;
    assign Busy         = !in_empty || (credits_used != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - self-checking bench for fpu_issue_ctrl with FPU model and scoreboard
module tb_fpu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        InValid;
    logic        InReady;
    logic [31:0] InOperand1;
    logic [31:0] InOperand2;
    logic [1:0]  InOperation;
    logic [31:0] FpuOperand1;
    logic [31:0] FpuOperand2;
    logic [1:0]  FpuOperation;
    logic [31:0] FpuResult;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutResult;
    logic [1:0]  OutOperation;
    logic        Busy;

    int          checks = 0;
    int          errors = 0;
    int          ndelivered = 0;
    int          nsent = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_v;
    logic [31:0] fp0;
    logic [31:0] fp1;

    always #5 CLK = ~CLK;

    fpu_issue_ctrl #(
        .IN_DEPTH  (4),
        .OUT_DEPTH (4),
        .LATENCY   (3)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .InValid      (InValid),
        .InReady      (InReady),
        .InOperand1   (InOperand1),
        .InOperand2   (InOperand2),
        .InOperation  (InOperation),
        .FpuOperand1  (FpuOperand1),
        .FpuOperand2  (FpuOperand2),
        .FpuOperation (FpuOperation),
        .FpuResult    (FpuResult),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutResult    (OutResult),
        .OutOperation (OutOperation),
        .Busy         (Busy)
    );

    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        return (a + b) ^ {op, 30'h0};
    endfunction

    function automatic logic [31:0] req_a(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] req_b(input int k);
        return 32'h0200_0000 + 32'(k * 3);
    endfunction

    // FPU stand-in: the operand registers are the first stage, two more stages follow.
    always @(posedge CLK) begin
        fp0 <= fmodel(FpuOperand1, FpuOperand2, FpuOperation);
        fp1 <= fp0;
    end
    assign FpuResult = fp1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (InValid && InReady)
                exp_q.push_back({fmodel(InOperand1, InOperand2, InOperation), InOperation});
            if (OutValid && OutReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL out_unexpected observed=%h expected=none", {OutResult, OutOperation});
                end else begin
                    exp_v = exp_q.pop_front();
                    assert ({OutResult, OutOperation} === exp_v) else begin
                        errors++;
                        $error("FAIL out_data observed=%h expected=%h", {OutResult, OutOperation}, exp_v);
                    end
                end
                ndelivered++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input int k);
        InValid     = 1'b1;
        InOperand1  = req_a(k);
        InOperand2  = req_b(k);
        InOperation = 2'(k);
    endtask

    task automatic send(input int k);
        logic take;
        present(k);
        for (int c = 0; c < 200; c++) begin
            take = InReady;
            step();
            if (take) begin
                nsent++;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 500 && ndelivered != nsent; c++) step();
        chk(tag, 64'(ndelivered), 64'(nsent));
        chk({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inready"},  64'(InReady),      64'd1);
        chk({tag, "_outvalid"}, 64'(OutValid),     64'd0);
        chk({tag, "_busy"},     64'(Busy),         64'd0);
        chk({tag, "_fpuop1"},   64'(FpuOperand1),  64'd0);
        chk({tag, "_fpuop2"},   64'(FpuOperand2),  64'd0);
        chk({tag, "_fpuopc"},   64'(FpuOperation), 64'd0);
        chk({tag, "_outres"},   64'(OutResult),    64'd0);
        chk({tag, "_outopc"},   64'(OutOperation), 64'd0);
    endtask

    initial begin
        logic take;
        int   nxt;
        int   d0;
        int   got;

        RST = 1'b1; InValid = 1'b0; InOperand1 = '0; InOperand2 = '0; InOperation = '0; OutReady = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs("reset");
        RST = 1'b0;
        step();

        // Single request: operands one edge after acceptance, result visible after t0+4.
        InValid = 1'b1; InOperand1 = 32'h3F80_0000; InOperand2 = 32'h4000_0000; InOperation = 2'b10;
        step();
        nsent++;
        InValid = 1'b0;
        chk("single_fpu_early", 64'(FpuOperand1), 64'd0);
        step();
        chk("single_fpuop1", 64'(FpuOperand1),  64'h3F80_0000);
        chk("single_fpuop2", 64'(FpuOperand2),  64'h4000_0000);
        chk("single_fpuopc", 64'(FpuOperation), 64'd2);
        chk("single_busy",   64'(Busy),         64'd1);
        step();
        step();
        chk("single_outvalid_early", 64'(OutValid), 64'd0);
        step();
        chk("single_outvalid", 64'(OutValid),     64'd1);
        chk("single_outres",   64'(OutResult),    64'(fmodel(32'h3F80_0000, 32'h4000_0000, 2'b10)));
        chk("single_outopc",   64'(OutOperation), 64'd2);
        step();
        chk("single_popped", 64'(OutValid), 64'd0);
        wait_drain("single_drain");
        chk("single_idle", 64'(Busy), 64'd0);

        // Back-to-back stream with the consumer always ready.
        OutReady = 1'b1;
        d0 = ndelivered;
        for (int k = 0; k < 20; k++) begin
            present(k);
            chk("b2b_inready", 64'(InReady), 64'd1);
            step();
            nsent++;
        end
        InValid = 1'b0;
        chk("b2b_rate_mid", 64'(ndelivered - d0), 64'd15);
        repeat (5) step();
        chk("b2b_rate_end", 64'(ndelivered - d0), 64'd20);
        wait_drain("b2b_drain");

        // Backpressure: four issued, eight accepted, then release with issue+pop at full credit.
        OutReady = 1'b0;
        for (int k = 100; k < 108; k++) send(k);
        present(108);
        repeat (6) step();
        chk("bp_inready",  64'(InReady),     64'd0);
        chk("bp_issued4",  64'(FpuOperand1), 64'(req_a(103)));
        chk("bp_outvalid", 64'(OutValid),    64'd1);
        chk("bp_busy",     64'(Busy),        64'd1);
        OutReady = 1'b1;
        nxt = 108;
        for (int i = 0; i < 4; i++) begin
            take = InValid && InReady;
            step();
            if (take) begin
                nsent++; nxt++;
                if (nxt < 110) present(nxt); else InValid = 1'b0;
            end
            chk("bp_issue_each_cycle", 64'(FpuOperand1), 64'(req_a(104 + i)));
            chk("bp_outvalid_held",    64'(OutValid),    64'd1);
        end
        for (int c = 0; c < 100 && nxt < 110; c++) begin
            take = InValid && InReady;
            step();
            if (take) begin
                nsent++; nxt++;
                if (nxt < 110) present(nxt); else InValid = 1'b0;
            end
        end
        InValid = 1'b0;
        wait_drain("bp_drain");

        // Reset with work queued and in flight.
        OutReady = 1'b0;
        for (int k = 200; k < 207; k++) send(k);
        InValid = 1'b0;
        RST = 1'b1;
        #2;
        chk_reset_outputs("midrst");
        exp_q.delete();
        nsent = ndelivered;
        step();
        step();
        RST = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midrst_no_stale", 64'(OutValid), 64'd0);
        end
        chk("midrst_idle", 64'(Busy), 64'd0);

        // Random handshakes on both sides.
        got = 0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            InValid     = ($urandom_range(0, 3) != 0);
            InOperand1  = $urandom;
            InOperand2  = $urandom;
            InOperation = 2'($urandom_range(0, 3));
            OutReady    = ($urandom_range(0, 2) != 0);
            take = InValid && InReady;
            step();
            if (take) begin
                got++;
                nsent++;
            end
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        chk("rand_sent", 64'(got), 64'd1000);
        wait_drain("rand_drain");
        chk("rand_idle", 64'(Busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
